alu_2_pc: RTL and testbench

// - Execute-stage core of the single-cycle Harvard MIPS32 CPU: PC register, ALU with HI/LO registers, and branch-target adder.
// - Sits between register file/decoder and next-PC muxes; alu_result feeds data_address and the write-back mux.

---
 rtl/alu_2_pc_if.sv | 35 +++
 rtl/alu_2_pc.sv | 159 +++++++++++++++
 tb/tb_alu_2_pc.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_2_pc_if.sv
// Execute-stage bundle between decoder/regfile, alu_2_pc and the next-PC muxes.
// master = decode/fetch side driving operands, slave = alu_2_pc.
interface alu_2_pc_if;
    logic        clk_enable;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  functcode;
    logic [4:0]  shamt;
    logic [4:0]  rt_sel;
    logic [15:0] immediate;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [31:0] alu_result;
    logic        sig_branch;
    logic [31:0] branch_address;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        overflow;

    modport master (
        output clk_enable, pc_in, opcode, functcode, shamt, rt_sel,
        output immediate, rs_content, rt_content,
        input  pc_out, pc_plus4, alu_result, sig_branch,
        input  branch_address, hi, lo, overflow
    );

    modport slave (
        input  clk_enable, pc_in, opcode, functcode, shamt, rt_sel,
        input  immediate, rs_content, rt_content,
        output pc_out, pc_plus4, alu_result, sig_branch,
        output branch_address, hi, lo, overflow
    );
endinterface

// File: rtl/alu_2_pc.sv
// MIPS32 execute core: PC register, ALU with HI/LO, branch-target adder.
// Define ALU_TRAP_EN to drive the signed overflow flag for ADD/SUB/ADDI.
module alu_2_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input logic       clk,
    input logic       reset,
    alu_2_pc_if.slave alu_io
);

    logic [31:0] pc_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] rs, rt;
    logic [31:0] sext, zext;
    logic [31:0] pc_p4, pc_p8;
    logic [31:0] sum_rr, dif_rr, sum_ri;
    logic [31:0] res;
    logic        br;

    assign op   = alu_io.opcode;
    assign fn   = alu_io.functcode;
    assign sh   = alu_io.shamt;
    assign rs   = alu_io.rs_content;
    assign rt   = alu_io.rt_content;
    assign sext = {{16{alu_io.immediate[15]}}, alu_io.immediate};
    assign zext = {16'h0, alu_io.immediate};

    assign pc_p4  = pc_q + 32'd4;
    assign pc_p8  = pc_q + 32'd8;
    assign sum_rr = rs + rt;
    assign dif_rr = rs - rt;
    assign sum_ri = rs + sext;

    // 64-bit products of extended operands; the low 64 bits are exact
    logic [63:0] mul_s, mul_u;
    assign mul_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign mul_u = {32'h0, rs} * {32'h0, rt};

    // Signed divide via magnitudes so MIN/-1 wraps instead of faulting
    logic [31:0] rs_mag, rt_mag, q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic        div_zero;
    assign div_zero = (rt == 32'h0);
    assign rs_mag   = rs[31] ? (32'h0 - rs) : rs;
    assign rt_mag   = rt[31] ? (32'h0 - rt) : rt;
    assign q_mag    = div_zero ? 32'h0 : rs_mag / rt_mag;
    assign r_mag    = div_zero ? 32'h0 : rs_mag % rt_mag;
    assign q_s      = (rs[31] ^ rt[31]) ? (32'h0 - q_mag) : q_mag;
    assign r_s      = rs[31] ? (32'h0 - r_mag) : r_mag;
    assign q_u      = div_zero ? 32'h0 : rs / rt;
    assign r_u      = div_zero ? 32'h0 : rs % rt;

    always_comb begin
        res = 32'h0;
        br  = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00: res = rt << sh;
                    6'h02: res = rt >> sh;
                    6'h03: res = $signed(rt) >>> sh;
                    6'h04: res = rt << rs[4:0];
                    6'h06: res = rt >> rs[4:0];
                    6'h07: res = $signed(rt) >>> rs[4:0];
                    6'h09: res = pc_p8;
                    6'h10: res = hi_q;
                    6'h12: res = lo_q;
                    6'h20, 6'h21: res = sum_rr;
                    6'h22, 6'h23: res = dif_rr;
                    6'h24: res = rs & rt;
                    6'h25: res = rs | rt;
                    6'h26: res = rs ^ rt;
                    6'h27: res = ~(rs | rt);
                    6'h2A: res = {31'h0, $signed(rs) < $signed(rt)};
                    6'h2B: res = {31'h0, rs < rt};
                    default: res = 32'h0;
                endcase
            end
            6'h01: begin
                case (alu_io.rt_sel)
                    5'h00: br = rs[31];
                    5'h01: br = ~rs[31];
                    5'h10: begin br = rs[31];  res = pc_p8; end
                    5'h11: begin br = ~rs[31]; res = pc_p8; end
                    default: br = 1'b0;
                endcase
            end
            6'h03: res = pc_p8;
            6'h04: br = (rs == rt);
            6'h05: br = (rs != rt);
            6'h06: br = rs[31] | (rs == 32'h0);
            6'h07: br = ~rs[31] & (rs != 32'h0);
            6'h08, 6'h09: res = sum_ri;
            6'h0A: res = {31'h0, $signed(rs) < $signed(sext)};
            6'h0B: res = {31'h0, rs < sext};
            6'h0C: res = rs & zext;
            6'h0D: res = rs | zext;
            6'h0E: res = rs ^ zext;
            6'h0F: res = {alu_io.immediate, 16'h0};
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27,
            6'h28, 6'h29, 6'h2A, 6'h2B: res = sum_ri;
            default: res = 32'h0;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op == 6'h00) begin
            case (fn)
                6'h11: hi_d = rs;
                6'h13: lo_d = rs;
                6'h18: {hi_d, lo_d} = mul_s;
                6'h19: {hi_d, lo_d} = mul_u;
                6'h1A: if (!div_zero) begin hi_d = r_s; lo_d = q_s; end
                6'h1B: if (!div_zero) begin hi_d = r_u; lo_d = q_u; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (alu_io.clk_enable) begin
            pc_q <= alu_io.pc_in;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef ALU_TRAP_EN
    logic ovf_add, ovf_sub, ovf_addi;
    assign ovf_add  = (rs[31] == rt[31]) && (sum_rr[31] != rs[31]);
    assign ovf_sub  = (rs[31] != rt[31]) && (dif_rr[31] != rs[31]);
    assign ovf_addi = (rs[31] == sext[31]) && (sum_ri[31] != rs[31]);
    assign alu_io.overflow = ((op == 6'h00) && (fn == 6'h20) && ovf_add)
                           | ((op == 6'h00) && (fn == 6'h22) && ovf_sub)
                           | ((op == 6'h08) && ovf_addi);
`else
    assign alu_io.overflow = 1'b0;
`endif

    assign alu_io.pc_out         = pc_q;
    assign alu_io.pc_plus4       = pc_p4;
    assign alu_io.alu_result     = res;
    assign alu_io.sig_branch     = br;
    assign alu_io.branch_address = pc_p4 + {sext[29:0], 2'b00};
    assign alu_io.hi             = hi_q;
    assign alu_io.lo             = lo_q;

endmodule

// File: tb/tb_alu_2_pc.sv
// Scoreboard bench for alu_2_pc: expectations queued at drive time,
// popped and compared once outputs settle.
module tb_alu_2_pc;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_2_pc_if bus ();
    alu_2_pc #(.RESET_VECTOR(32'hBFC0_0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .alu_io (bus.slave)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int S_RES = 0, S_BR = 1, S_BA = 2, S_PC = 3;
    localparam int S_P4 = 4, S_HI = 5, S_LO = 6, S_OV = 7;

`ifdef ALU_TRAP_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RES:   return bus.alu_result;
            S_BR:    return {31'h0, bus.sig_branch};
            S_BA:    return bus.branch_address;
            S_PC:    return bus.pc_out;
            S_P4:    return bus.pc_plus4;
            S_HI:    return bus.hi;
            S_LO:    return bus.lo;
            default: return {31'h0, bus.overflow};
        endcase
    endfunction

    task automatic want(input string tag, input int sel,
                        input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] sh, input logic [4:0] rts,
                         input logic [15:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input logic ce);
        bus.opcode     = o;
        bus.functcode  = f;
        bus.shamt      = sh;
        bus.rt_sel     = rts;
        bus.immediate  = imm;
        bus.rs_content = a;
        bus.rt_content = b;
        bus.clk_enable = ce;
    endtask

    task automatic settle(input bit seq);
        if (seq) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            #1;
        end
        drain();
    endtask

    initial begin
        bus.pc_in = 32'hBFC0_0004;
        issue(6'h3F, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        want("rst_pc", S_PC, 32'hBFC0_0000);
        want("rst_hi", S_HI, 32'h0);
        want("rst_lo", S_LO, 32'h0);
        settle(0);

        bus.clk_enable = 1'b1;
        want("pc_adv", S_PC, 32'hBFC0_0004);
        want("pc_p4", S_P4, 32'hBFC0_0008);
        settle(1);

        bus.clk_enable = 1'b0;
        bus.pc_in = 32'h1234_5678;
        want("pc_hold", S_PC, 32'hBFC0_0004);
        settle(1);

        bus.clk_enable = 1'b1;
        bus.pc_in = 32'hBFC0_0010;
        want("pc_set", S_PC, 32'hBFC0_0010);
        settle(1);

        // combinational ops with state frozen
        issue(6'h00, 6'h21, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        want("addu", S_RES, 32'h0);
        settle(0);
        issue(6'h00, 6'h2A, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        want("slt", S_RES, 32'h1);
        settle(0);
        issue(6'h00, 6'h2B, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        want("sltu", S_RES, 32'h0);
        settle(0);
        issue(6'h00, 6'h03, 5'd4, 5'd0, 16'h0, 32'h0, 32'h8000_0000, 1'b0);
        want("sra", S_RES, 32'hF800_0000);
        settle(0);
        issue(6'h00, 6'h07, 5'd0, 5'd0, 16'h0, 32'h4, 32'h8000_0000, 1'b0);
        want("srav", S_RES, 32'hF800_0000);
        settle(0);
        issue(6'h00, 6'h00, 5'd31, 5'd0, 16'h0, 32'h0, 32'h1, 1'b0);
        want("sll", S_RES, 32'h8000_0000);
        settle(0);
        issue(6'h00, 6'h06, 5'd0, 5'd0, 16'h0, 32'h24, 32'h8000_0000, 1'b0);
        want("srlv", S_RES, 32'h0800_0000);
        settle(0);
        issue(6'h00, 6'h23, 5'd0, 5'd0, 16'h0, 32'h0, 32'h1, 1'b0);
        want("subu", S_RES, 32'hFFFF_FFFF);
        settle(0);
        issue(6'h00, 6'h27, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("nor", S_RES, 32'hFFFF_FFFF);
        settle(0);
        issue(6'h0F, 6'h00, 5'd0, 5'd0, 16'h1234, 32'h0, 32'h0, 1'b0);
        want("lui", S_RES, 32'h1234_0000);
        settle(0);
        issue(6'h0D, 6'h00, 5'd0, 5'd0, 16'h8001, 32'hFFFF_0000, 32'h0, 1'b0);
        want("ori", S_RES, 32'hFFFF_8001);
        settle(0);
        issue(6'h09, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h10, 32'h0, 1'b0);
        want("addiu", S_RES, 32'hF);
        settle(0);
        issue(6'h0B, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h5, 32'h0, 1'b0);
        want("sltiu", S_RES, 32'h1);
        settle(0);
        issue(6'h23, 6'h00, 5'd0, 5'd0, 16'hFFFC, 32'h1000, 32'h0, 1'b0);
        want("lw_ea", S_RES, 32'hFFC);
        settle(0);
        issue(6'h00, 6'h09, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("jalr", S_RES, 32'hBFC0_0018);
        settle(0);
        issue(6'h03, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("jal", S_RES, 32'hBFC0_0018);
        settle(0);
        issue(6'h04, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h5, 32'h5, 1'b0);
        want("beq_br", S_BR, 32'h1);
        want("beq_ba", S_BA, 32'hBFC0_0010);
        settle(0);
        issue(6'h05, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h5, 32'h5, 1'b0);
        want("bne_br", S_BR, 32'h0);
        settle(0);
        issue(6'h06, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("blez", S_BR, 32'h1);
        settle(0);
        issue(6'h07, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("bgtz", S_BR, 32'h0);
        settle(0);
        issue(6'h01, 6'h00, 5'd0, 5'h10, 16'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        want("bltzal_br", S_BR, 32'h1);
        want("bltzal_res", S_RES, 32'hBFC0_0018);
        settle(0);
        issue(6'h01, 6'h00, 5'd0, 5'h01, 16'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        want("bgez", S_BR, 32'h0);
        settle(0);
        issue(6'h3F, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h5, 32'h5, 1'b0);
        want("unl_res", S_RES, 32'h0);
        want("unl_br", S_BR, 32'h0);
        settle(0);
        issue(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        want("add_res", S_RES, 32'h8000_0000);
        want("add_ovf", S_OV, {31'h0, OVF_EXP});
        settle(0);
        issue(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 32'h1, 32'h1, 1'b0);
        want("add_noovf", S_OV, 32'h0);
        settle(0);

        // HI/LO state updates; PC re-loads its own value
        bus.pc_in = 32'hBFC0_0010;
        issue(6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'h3, 1'b0);
        want("mult_ce0", S_HI, 32'h0);
        settle(1);
        issue(6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'h3, 1'b1);
        want("mult_hi", S_HI, 32'hFFFF_FFFF);
        want("mult_lo", S_LO, 32'hFFFF_FFFA);
        settle(1);
        issue(6'h00, 6'h10, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("mfhi", S_RES, 32'hFFFF_FFFF);
        settle(0);
        issue(6'h00, 6'h19, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'h3, 1'b1);
        want("multu_hi", S_HI, 32'h2);
        want("multu_lo", S_LO, 32'hFFFF_FFFA);
        settle(1);
        issue(6'h00, 6'h12, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        want("mflo", S_RES, 32'hFFFF_FFFA);
        settle(0);
        issue(6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFF9, 32'h2, 1'b1);
        want("div_lo", S_LO, 32'hFFFF_FFFD);
        want("div_hi", S_HI, 32'hFFFF_FFFF);
        settle(1);
        issue(6'h00, 6'h1B, 5'd0, 5'd0, 16'h0, 32'h9, 32'h0, 1'b1);
        want("divu0_lo", S_LO, 32'hFFFF_FFFD);
        want("divu0_hi", S_HI, 32'hFFFF_FFFF);
        settle(1);
        issue(6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        want("divmin_lo", S_LO, 32'h8000_0000);
        want("divmin_hi", S_HI, 32'h0);
        settle(1);
        issue(6'h00, 6'h1B, 5'd0, 5'd0, 16'h0, 32'h7, 32'h2, 1'b1);
        want("divu_lo", S_LO, 32'h3);
        want("divu_hi", S_HI, 32'h1);
        settle(1);
        issue(6'h00, 6'h11, 5'd0, 5'd0, 16'h0, 32'hAAAA_5555, 32'h0, 1'b1);
        want("mthi", S_HI, 32'hAAAA_5555);
        settle(1);
        issue(6'h00, 6'h13, 5'd0, 5'd0, 16'h0, 32'h1357_9BDF, 32'h0, 1'b1);
        want("mtlo", S_LO, 32'h1357_9BDF);
        want("pc_keep", S_PC, 32'hBFC0_0010);
        settle(1);

        // reset must win over clk_enable=0
        issue(6'h3F, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        want("rst2_pc", S_PC, 32'hBFC0_0000);
        want("rst2_hi", S_HI, 32'h0);
        want("rst2_lo", S_LO, 32'h0);
        settle(1);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
